// File: rtl/stack_ctrl.sv
// Purpose: stack-machine controller driving a 128x8 falling-edge RAM; push/pop/top/add/sub/clear on a downward-growing stack.
// Latency: accept-to-done is PUSH 2, POP/TOP 2, ADD/SUB 4, CLEAR 1 cycles; rejected commands finish in 1 cycle.
// Backpressure: busy is high outside IDLE; op_valid is only sampled in IDLE and is otherwise dropped, never queued.
module stack_ctrl #(
  parameter int              DEPTH    = 128,
  parameter int              AW       = 7,
  parameter int              CW       = 8,
  parameter logic [AW-1:0]   TOP_ADDR = 7'h7F
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [2:0]    op,
  input  logic [7:0]    data_in,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    top_data,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] sp,
  output logic [CW-1:0] count,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD_A = 3'd2,
    S_RD_B = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;
  localparam logic [2:0] OP_TOP   = 3'd5;

  localparam logic [AW-1:0] SP_ONE   = AW'(1);
  localparam logic [AW-1:0] SP_TWO   = AW'(2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  state_t        state, state_nxt;
  logic [2:0]    op_r;
  logic [7:0]    opnd_r;
  logic [7:0]    a_r;
  logic [7:0]    b_r;
  logic          err_r;
  logic [AW-1:0] sp_r;
  logic [CW-1:0] count_r;
  logic [7:0]    top_r;

  logic          reject;
  logic          is_arith;
  logic [7:0]    alu_res;

  assign empty    = (count_r == '0);
  assign full     = (count_r == CNT_FULL);
  assign sp       = sp_r;
  assign count    = count_r;
  assign top_data = top_r;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  // error is meaningful only alongside done; keep it low otherwise
  assign error    = done & err_r;

  // The second operand sits deeper in the stack, so SUB is b - a (next-to-top minus top)
  assign is_arith = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign alu_res  = (op_r == OP_SUB) ? (b_r - a_r) : (b_r + a_r);

  // Decide at accept time whether the incoming command can legally run
  always_comb begin
    reject = 1'b0;
    case (op)
      OP_PUSH:         reject = full;
      OP_POP, OP_TOP:  reject = empty;
      OP_ADD, OP_SUB:  reject = (count_r < CNT_TWO);
      OP_CLEAR:        reject = 1'b0;
      default:         reject = 1'b1;
    endcase
  end

  // State register; reset aborts any command without producing a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and RAM-port decode; RAM signals are pure functions of state and stack pointer
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          if (reject) begin
            state_nxt = S_DONE;
          end else begin
            case (op)
              OP_PUSH:                 state_nxt = S_WR;
              OP_POP, OP_TOP:          state_nxt = S_RD_A;
              OP_ADD, OP_SUB:          state_nxt = S_RD_A;
              default:                 state_nxt = S_DONE;
            endcase
          end
        end
      end
      S_WR: begin
        mem_we    = 1'b1;
        mem_addr  = sp_r;
        mem_din   = opnd_r;
        state_nxt = S_DONE;
      end
      S_RD_A: begin
        mem_addr  = sp_r + SP_ONE;
        state_nxt = is_arith ? S_RD_B : S_DONE;
      end
      S_RD_B: begin
        mem_addr  = sp_r + SP_TWO;
        state_nxt = S_WB;
      end
      S_WB: begin
        // The result overwrites the deeper operand, which becomes the new top
        mem_we    = 1'b1;
        mem_addr  = sp_r + SP_TWO;
        mem_din   = alu_res;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch, operand capture and stack-pointer bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r    <= '0;
      opnd_r  <= '0;
      a_r     <= '0;
      b_r     <= '0;
      err_r   <= 1'b0;
      sp_r    <= TOP_ADDR;
      count_r <= '0;
      top_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_r   <= op;
            opnd_r <= data_in;
            err_r  <= reject;
            // CLEAR needs no RAM access, so it takes effect at accept
            if (op == OP_CLEAR) begin
              sp_r    <= TOP_ADDR;
              count_r <= '0;
            end
          end
        end
        S_WR: begin
          sp_r    <= sp_r - SP_ONE;
          count_r <= count_r + CNT_ONE;
          top_r   <= opnd_r;
        end
        S_RD_A: begin
          // mem_dout now holds the word addressed during this cycle
          a_r <= mem_dout;
          if ((op_r == OP_POP) || (op_r == OP_TOP)) begin
            top_r <= mem_dout;
          end
          if (op_r == OP_POP) begin
            sp_r    <= sp_r + SP_ONE;
            count_r <= count_r - CNT_ONE;
          end
        end
        S_RD_B: begin
          b_r <= mem_dout;
        end
        S_WB: begin
          sp_r    <= sp_r + SP_ONE;
          count_r <= count_r - CNT_ONE;
          top_r   <= alu_res;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;
  localparam logic [2:0] OP_TOP   = 3'd5;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic [2:0] op;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] top_data;
  logic       empty;
  logic       full;
  logic [6:0] sp;
  logic [7:0] count;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  logic [7:0] ram [0:127];
  int         total;
  int         bad;
  int         we_cnt;
  int         done_cnt;

  stack_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .top_data (top_data),
    .empty    (empty),
    .full     (full),
    .sp       (sp),
    .count    (count),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: samples address/write on the falling edge, registered read
  always @(negedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  // Activity monitors sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from IDLE; lat counts rising edges from accept (inclusive) until done is seen
  task automatic do_op(input logic [2:0] o, input logic [7:0] d, output int lat, output logic err);
    lat = 99;
    err = 1'bx;
    op_valid = 1'b1;
    op       = o;
    data_in  = d;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (done) begin
        lat = n;
        err = error;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  int         lat;
  logic       err;
  int         push_errs;
  int         w0;
  int         d0;

  initial begin
    total = 0; bad = 0; we_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 128; i++) ram[i] = 8'h00;
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp", sp, 7'h7F);
    chk("rst_count", count, 8'd0);
    chk("rst_flags", {busy, done, error, empty, full}, 5'b00010);
    chk("rst_top", top_data, 8'h00);
    chk("rst_mem", {mem_we, mem_addr, mem_din}, 16'h0000);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // two pushes
    do_op(OP_PUSH, 8'h05, lat, err);
    chk("push1_lat", lat, 2);
    chk("push1_err", err, 1'b0);
    do_op(OP_PUSH, 8'h03, lat, err);
    chk("push2_lat", lat, 2);
    chk("push2_err", err, 1'b0);
    chk("push_ram7f", ram[7'h7F], 8'h05);
    chk("push_ram7e", ram[7'h7E], 8'h03);
    chk("push_sp", sp, 7'h7D);
    chk("push_count", count, 8'd2);

    // ADD 05 + 03
    do_op(OP_ADD, 8'h00, lat, err);
    chk("add_lat", lat, 4);
    chk("add_err", err, 1'b0);
    chk("add_ram7f", ram[7'h7F], 8'h08);
    chk("add_top", top_data, 8'h08);
    chk("add_sp", sp, 7'h7E);
    chk("add_count", count, 8'd1);

    // SUB 05 - 03
    do_op(OP_CLEAR, 8'h00, lat, err);
    do_op(OP_PUSH, 8'h05, lat, err);
    do_op(OP_PUSH, 8'h03, lat, err);
    do_op(OP_SUB, 8'h00, lat, err);
    chk("sub1_lat", lat, 4);
    chk("sub1_top", top_data, 8'h02);
    chk("sub1_ram", ram[7'h7F], 8'h02);

    // SUB 03 - 05 wraps modulo 256
    do_op(OP_CLEAR, 8'h00, lat, err);
    do_op(OP_PUSH, 8'h03, lat, err);
    do_op(OP_PUSH, 8'h05, lat, err);
    do_op(OP_SUB, 8'h00, lat, err);
    chk("sub2_top", top_data, 8'hFE);
    chk("sub2_ram", ram[7'h7F], 8'hFE);

    // TOP peeks without moving the stack
    do_op(OP_CLEAR, 8'h00, lat, err);
    do_op(OP_PUSH, 8'h3C, lat, err);
    do_op(OP_PUSH, 8'h77, lat, err);
    do_op(OP_POP, 8'h00, lat, err);
    do_op(OP_TOP, 8'h00, lat, err);
    chk("top_lat", lat, 2);
    chk("top_val", top_data, 8'h3C);
    chk("top_spcnt", {sp, count}, {7'h7E, 8'd1});

    // POP last entry, then POP on empty
    do_op(OP_CLEAR, 8'h00, lat, err);
    do_op(OP_PUSH, 8'hA5, lat, err);
    do_op(OP_POP, 8'h00, lat, err);
    chk("pop_lat", lat, 2);
    chk("pop_top", top_data, 8'hA5);
    chk("pop_state", {empty, sp}, {1'b1, 7'h7F});
    w0 = we_cnt;
    do_op(OP_POP, 8'h00, lat, err);
    chk("pop_empty_err", {lat[3:0], err}, {4'd1, 1'b1});
    chk("pop_empty_we", we_cnt - w0, 0);
    chk("pop_empty_sp", sp, 7'h7F);
    chk("pop_empty_top", top_data, 8'hA5);

    // ADD with fewer than two entries
    do_op(OP_ADD, 8'h00, lat, err);
    chk("add_cnt0_err", {lat[3:0], err}, {4'd1, 1'b1});
    do_op(OP_PUSH, 8'h09, lat, err);
    do_op(OP_SUB, 8'h00, lat, err);
    chk("sub_cnt1_err", {lat[3:0], err}, {4'd1, 1'b1});
    chk("sub_cnt1_cnt", count, 8'd1);

    // fill the stack
    do_op(OP_CLEAR, 8'h00, lat, err);
    chk("clear_lat", lat, 1);
    push_errs = 0;
    for (int i = 0; i < 128; i++) begin
      do_op(OP_PUSH, 8'(i), lat, err);
      if (err !== 1'b0 || lat != 2) push_errs++;
    end
    chk("fill_errs", push_errs, 0);
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 8'd128);
    chk("fill_sp", sp, 7'h7F);
    chk("fill_ram0", ram[0], 8'd127);
    chk("fill_ram7f", ram[7'h7F], 8'd0);
    w0 = we_cnt;
    do_op(OP_PUSH, 8'hEE, lat, err);
    chk("over_err", {lat[3:0], err}, {4'd1, 1'b1});
    chk("over_ram0", ram[0], 8'd127);
    chk("over_we", we_cnt - w0, 0);
    chk("over_count", count, 8'd128);
    do_op(OP_CLEAR, 8'h00, lat, err);
    chk("clr_err", err, 1'b0);
    chk("clr_state", {empty, full, sp, count}, {1'b1, 1'b0, 7'h7F, 8'd0});

    // reset during RD_B of an ADD
    do_op(OP_PUSH, 8'h11, lat, err);
    do_op(OP_PUSH, 8'h22, lat, err);
    d0 = done_cnt;
    op_valid = 1'b1; op = OP_ADD; data_in = 8'h00;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    chk("rdb_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_flags", {busy, done}, 2'b00);
    chk("rst_mid_sp", sp, 7'h7F);
    chk("rst_mid_count", count, 8'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_nodone", done_cnt - d0, 0);
    chk("rst_mid_ram", {ram[7'h7F], ram[7'h7E]}, 16'h1122);

    // op_valid held high across a whole push: exactly one push
    d0 = done_cnt;
    op_valid = 1'b1; op = OP_PUSH; data_in = 8'h40;
    repeat (3) @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_count", count, 8'd1);
    chk("hold_dones", done_cnt - d0, 1);
    chk("hold_ram", ram[7'h7F], 8'h40);

    // illegal opcodes
    do_op(3'd6, 8'h00, lat, err);
    chk("op6_err", {lat[3:0], err}, {4'd1, 1'b1});
    chk("op6_state", {sp, count, top_data}, {7'h7E, 8'd1, 8'h40});
    do_op(3'd7, 8'h00, lat, err);
    chk("op7_err", {lat[3:0], err}, {4'd1, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
